// File: rtl/mac_tile_mc_if.sv
// mac_tile_mc_if: neighbour-facing bus of one multi-channel systolic MAC tile.
interface mac_tile_mc_if #(
    parameter int bw = 4,
    parameter int psum_bw = 16,
    parameter int ch = 2
);
    logic                format;
    logic [1:0]          inst_w;
    logic [1:0]          inst_e;
    logic [bw*ch-1:0]    in_w;
    logic [bw*ch-1:0]    out_e;
    logic [psum_bw-1:0]  in_n;
    logic [psum_bw-1:0]  out_s;
    logic                overwrite;
    logic                flush;
    logic                valid;
    logic                loaded;

    modport master (
        output format, inst_w, in_w, in_n, overwrite, flush,
        input  inst_e, out_e, out_s, valid, loaded
    );
    modport slave (
        input  format, inst_w, in_w, in_n, overwrite, flush,
        output inst_e, out_e, out_s, valid, loaded
    );
endinterface

// File: rtl/mac_tile_mc.sv
// mac_tile_mc: ch-wide WS/OS systolic MAC cell with one-cycle registered east/south forwarding.
// Define MAC_TILE_SAT_EN to clamp WS results and OS accumulator updates instead of wrapping.
module mac_tile_mc #(
    parameter int bw = 4,
    parameter int psum_bw = 16,
    parameter int ch = 2
) (
    input  logic clk,
    input  logic reset,
    mac_tile_mc_if.slave bus
);
`ifdef MAC_TILE_SAT_EN
    localparam int ew = psum_bw + 2;
    localparam logic signed [ew-1:0] smax = {3'b000, {(psum_bw-1){1'b1}}};
    localparam logic signed [ew-1:0] smin = ~smax;
`else
    // Wrapping is modular, so the extra guard bits would never reach the output.
    localparam int ew = psum_bw;
`endif

    typedef enum logic [1:0] {EMPTY, LOADED, ACC} state_t;

    state_t               state;
    state_t               st_ws;
    logic                 format_q;
    logic                 chg;
    logic [bw*ch-1:0]     w_q;
    logic [bw*ch-1:0]     w_use;
    logic [psum_bw-1:0]   acc;
    logic [psum_bw-1:0]   acc_use;
    logic signed [ew-1:0] dot_ws;
    logic signed [ew-1:0] dot_os;
    logic signed [ew-1:0] sum_ws;
    logic signed [ew-1:0] sum_os;

    function automatic logic [psum_bw-1:0] fit(input logic signed [ew-1:0] x);
`ifdef MAC_TILE_SAT_EN
        return x > smax ? smax[psum_bw-1:0] : x < smin ? smin[psum_bw-1:0] : x[psum_bw-1:0];
`else
        return x;
`endif
    endfunction

    // A format change acts as if the tile had just been cleared for this cycle.
    always_comb begin
        chg = bus.format != format_q;
        st_ws = chg ? EMPTY : state;
        w_use = chg ? '0 : w_q;
        acc_use = chg ? '0 : acc;
        dot_ws = '0;
        dot_os = '0;
        for (int k = 0; k < ch; k++) begin
            dot_ws += ew'($signed({1'b0, bus.in_w[k*bw +: bw]})) * ew'($signed(w_use[k*bw +: bw]));
            dot_os += ew'($signed({1'b0, bus.in_w[k*bw +: bw]})) * ew'($signed(bus.in_n[k*bw +: bw]));
        end
        sum_ws = ew'($signed(bus.in_n)) + dot_ws;
        sum_os = ew'($signed(acc_use)) + dot_os;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ACC;
            format_q   <= 1'b0;
            w_q        <= '0;
            acc        <= '0;
            bus.inst_e <= '0;
            bus.out_e  <= '0;
            bus.out_s  <= '0;
            bus.valid  <= 1'b0;
            bus.loaded <= 1'b0;
        end else begin
            format_q  <= bus.format;
            bus.valid <= 1'b0;
            if (chg) begin
                w_q <= '0;
                acc <= '0;
            end
            if (bus.format) begin
                if (|bus.inst_w) bus.out_e <= bus.in_w;
                bus.inst_e <= {bus.inst_w[1], st_ws == LOADED && bus.inst_w[0]};
                if (st_ws == LOADED && bus.overwrite) begin
                    state      <= EMPTY;
                    w_q        <= '0;
                    bus.loaded <= 1'b0;
                end else if (st_ws == EMPTY && bus.inst_w[0]) begin
                    state      <= LOADED;
                    w_q        <= bus.in_w;
                    bus.loaded <= 1'b1;
                end else begin
                    state      <= st_ws;
                    bus.loaded <= st_ws == LOADED;
                end
                if (bus.inst_w[1]) begin
                    bus.out_s <= fit(sum_ws);
                    bus.valid <= !chg;
                end
            end else begin
                state      <= ACC;
                bus.loaded <= 1'b0;
                bus.inst_e <= bus.inst_w;
                if (bus.inst_w[0]) bus.out_e <= bus.in_w;
                // Flush wins: the column shift must not be disturbed by a late execute.
                if (bus.flush) begin
                    bus.out_s <= acc_use;
                    acc       <= bus.in_n;
                    bus.valid <= !chg;
                end else if (bus.inst_w[0]) begin
                    acc       <= fit(sum_os);
                    bus.out_s <= psum_bw'(bus.in_n[bw*ch-1:0]);
                end
            end
        end
    end
endmodule

// File: tb/tb_mac_tile_mc.sv
// tb_mac_tile_mc: directed WS/OS vectors with a queue scoreboard on valid results.
module tb_mac_tile_mc;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    mac_tile_mc_if #(.bw(4), .psum_bw(16), .ch(2)) bus ();
    mac_tile_mc #(.bw(4), .psum_bw(16), .ch(2)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] inst, input logic [7:0] w, input logic [15:0] n, input logic ov, input logic fl);
        bus.inst_w = inst;
        bus.in_w = w;
        bus.in_n = n;
        bus.overwrite = ov;
        bus.flush = fl;
    endtask

    always @(negedge clk) begin
        if (reset && bus.valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got out_s %0h expected no result", bus.out_s);
            end else begin
                chk("out_s", 32'(bus.out_s), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        bus.format = 1'b0;
        drive(2'b00, 8'h00, 16'h0, 1'b0, 1'b0);
        step();
        step();
        chk("rst_out_s", 32'(bus.out_s), 0);
        chk("rst_valid", 32'(bus.valid), 0);
        chk("rst_loaded", 32'(bus.loaded), 0);
        chk("rst_inst_e", 32'(bus.inst_e), 0);
        chk("rst_out_e", 32'(bus.out_e), 0);
        reset = 1'b1;
        bus.format = 1'b1;
        drive(2'b01, 8'hE3, 16'd0, 1'b0, 1'b0);
        step();
        chk("load_absorbed", 32'(bus.inst_e), 0);
        chk("loaded", 32'(bus.loaded), 1);
        drive(2'b10, 8'h54, 16'd100, 1'b0, 1'b0);
        exp_q.push_back(16'd102);
        step();
        chk("ws_out_e", 32'(bus.out_e), 32'h54);
        chk("ws_inst_e", 32'(bus.inst_e), 32'b10);
        drive(2'b10, 8'h11, 16'd0, 1'b0, 1'b0);
        exp_q.push_back(16'd1);
        step();
        drive(2'b00, 8'h99, 16'd0, 1'b0, 1'b0);
        step();
        chk("idle_valid", 32'(bus.valid), 0);
        chk("idle_out_e_hold", 32'(bus.out_e), 32'h11);
        drive(2'b01, 8'h77, 16'd0, 1'b0, 1'b0);
        step();
        chk("reload_forward", 32'(bus.inst_e), 32'b01);
        drive(2'b10, 8'h54, 16'd100, 1'b0, 1'b0);
        exp_q.push_back(16'd102);
        step();
        drive(2'b01, 8'h66, 16'd0, 1'b1, 1'b0);
        step();
        chk("overwrite_loaded", 32'(bus.loaded), 0);
        drive(2'b10, 8'h54, 16'd55, 1'b0, 1'b0);
        exp_q.push_back(16'd55);
        step();
        drive(2'b01, 8'h11, 16'd0, 1'b0, 1'b0);
        step();
        chk("reload_absorbed", 32'(bus.inst_e), 0);
        chk("reload_loaded", 32'(bus.loaded), 1);
        drive(2'b10, 8'h22, 16'd0, 1'b0, 1'b0);
        exp_q.push_back(16'd4);
        step();
        drive(2'b00, 8'h00, 16'd0, 1'b1, 1'b0);
        step();
        drive(2'b01, 8'h77, 16'd0, 1'b0, 1'b0);
        step();
        drive(2'b10, 8'hFF, 16'd32760, 1'b0, 1'b0);
`ifdef MAC_TILE_SAT_EN
        exp_q.push_back(16'h7FFF);
`else
        exp_q.push_back(16'h80CA);
`endif
        step();
        bus.format = 1'b0;
        drive(2'b00, 8'h00, 16'd0, 1'b0, 1'b0);
        step();
        chk("fmt_chg_valid", 32'(bus.valid), 0);
        chk("fmt_chg_loaded", 32'(bus.loaded), 0);
        drive(2'b01, 8'h12, 16'h0011, 1'b0, 1'b0);
        step();
        chk("os_weights_south", 32'(bus.out_s), 32'h11);
        chk("os_exec_valid", 32'(bus.valid), 0);
        chk("os_inst_e", 32'(bus.inst_e), 32'b01);
        step();
        step();
        drive(2'b00, 8'h00, 16'd7, 1'b0, 1'b1);
        exp_q.push_back(16'd9);
        step();
        drive(2'b00, 8'h00, 16'd0, 1'b0, 1'b1);
        exp_q.push_back(16'd7);
        step();
        drive(2'b01, 8'h12, 16'h0011, 1'b0, 1'b1);
        exp_q.push_back(16'd0);
        step();
        drive(2'b00, 8'h00, 16'd0, 1'b0, 1'b1);
        exp_q.push_back(16'h0011);
        step();
        drive(2'b01, 8'h12, 16'h0011, 1'b0, 1'b0);
        step();
        bus.format = 1'b1;
        drive(2'b00, 8'h00, 16'd0, 1'b0, 1'b0);
        step();
        chk("toggle_valid", 32'(bus.valid), 0);
        chk("toggle_loaded", 32'(bus.loaded), 0);
        bus.format = 1'b0;
        step();
        drive(2'b00, 8'h00, 16'd0, 1'b0, 1'b1);
        exp_q.push_back(16'd0);
        step();
        bus.format = 1'b1;
        drive(2'b01, 8'hE3, 16'd0, 1'b0, 1'b0);
        step();
        chk("pre_reset_loaded", 32'(bus.loaded), 1);
        drive(2'b10, 8'h54, 16'd100, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("async_out_s", 32'(bus.out_s), 0);
        chk("async_valid", 32'(bus.valid), 0);
        chk("async_loaded", 32'(bus.loaded), 0);
        chk("async_inst_e", 32'(bus.inst_e), 0);
        chk("async_out_e", 32'(bus.out_e), 0);
        step();
        reset = 1'b1;
        drive(2'b01, 8'hE3, 16'd0, 1'b0, 1'b0);
        step();
        chk("post_reset_absorbed", 32'(bus.inst_e), 0);
        chk("post_reset_loaded", 32'(bus.loaded), 1);
        drive(2'b10, 8'h54, 16'd100, 1'b0, 1'b0);
        exp_q.push_back(16'd102);
        step();
        drive(2'b00, 8'h00, 16'd0, 1'b0, 1'b0);
        step();
        step();
        chk("results_outstanding", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
